// File: rtl/cpu_register_pkg.sv
// Shared types and defaults for the CPU register bank.
package cpu_register_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    INC = 2'd1,
    DEC = 2'd2,
    CLR = 2'd3
  } cnt_op_t;

endpackage

// File: rtl/cpu_register_cell.sv
// One register of the bank: load has priority over the counter op; flags a
// wrap-around of the op applied this cycle.
module cpu_register_cell
  import cpu_register_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  cnt_op_t          i_op,
  output logic [WIDTH-1:0] o_q,
  output logic             o_wrap_c
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap;

  // Next value; wrap only when the op itself crosses the modulus boundary.
  always_comb begin
    w_next = r_q;
    w_wrap = 1'b0;
    if (i_load) begin
      w_next = i_data;
    end else begin
      case (i_op)
        INC: begin
          w_next = r_q + WIDTH'(1);
          w_wrap = &r_q;
        end
        DEC: begin
          w_next = r_q - WIDTH'(1);
          w_wrap = ~|r_q;
        end
        CLR:     w_next = '0;
        default: w_next = r_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= w_next;
    end
  end

  assign o_q      = r_q;
  assign o_wrap_c = w_wrap;

endmodule

// File: rtl/cpu_register_bank.sv
// DEPTH x WIDTH register bank with write port, counter-op port, tristate bus
// read and direct read. Define CPU_REGISTER_BANK_BYPASS_EN to forward data_in.
module cpu_register_bank
  import cpu_register_pkg::*;
#(
  parameter  int unsigned WIDTH  = DEF_WIDTH,
  parameter  int unsigned DEPTH  = DEF_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [1:0]        cnt_op,
  input  logic [ADDR_W-1:0] cnt_addr,
  input  logic              bus_oe,
  input  logic [ADDR_W-1:0] bus_addr,
  output wire  [WIDTH-1:0]  q_bus,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  q,
  output logic              zero,
  output logic              wrap
);

  logic [WIDTH-1:0] w_reg [DEPTH];
  logic [DEPTH-1:0] w_load;
  logic [DEPTH-1:0] w_wrap_c;
  cnt_op_t          w_op [DEPTH];
  logic             w_collide;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_bus_q;
  logic             r_wrap;

  // A load to the counter-op target discards the op entirely.
  assign w_collide = load && (load_addr == cnt_addr);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
    assign w_load[gi] = load && (load_addr == ADDR_W'(gi));
    assign w_op[gi]   = ((cnt_addr == ADDR_W'(gi)) && !w_collide) ?
                        cnt_op_t'(cnt_op) : NOP;

    cpu_register_cell #(
      .WIDTH (WIDTH)
    ) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_load[gi]),
      .i_data   (data_in),
      .i_op     (w_op[gi]),
      .o_q      (w_reg[gi]),
      .o_wrap_c (w_wrap_c[gi])
    );
  end

`ifdef CPU_REGISTER_BANK_BYPASS_EN
  assign w_q     = (load && (load_addr == rd_addr))  ? data_in : w_reg[rd_addr];
  assign w_bus_q = (load && (load_addr == bus_addr)) ? data_in : w_reg[bus_addr];
`else
  assign w_q     = w_reg[rd_addr];
  assign w_bus_q = w_reg[bus_addr];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= |w_wrap_c;
    end
  end

  assign q     = w_q;
  assign zero  = (w_q == '0);
  assign wrap  = r_wrap;
  assign q_bus = bus_oe ? w_bus_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_cpu_register_bank.sv
// Self-checking bench for cpu_register_bank: vector table with scoreboard plus
// hand-written reset, latency, wrap-pulse and wide-configuration sequences.
module tb_cpu_register_bank;
  import cpu_register_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic [1:0]  load_addr = '0;
  logic [7:0]  data_in = '0;
  logic [1:0]  cnt_op = '0;
  logic [1:0]  cnt_addr = '0;
  logic        bus_oe = 1'b0;
  logic [1:0]  bus_addr = '0;
  logic [1:0]  rd_addr = '0;
  wire  [7:0]  q_bus;
  logic [7:0]  q;
  logic        zero;
  logic        wrap;

  logic        p_load = 1'b0;
  logic [2:0]  p_load_addr = '0;
  logic [15:0] p_data_in = '0;
  logic [1:0]  p_cnt_op = '0;
  logic [2:0]  p_cnt_addr = '0;
  logic        p_bus_oe = 1'b0;
  logic [2:0]  p_bus_addr = '0;
  logic [2:0]  p_rd_addr = '0;
  wire  [15:0] p_q_bus;
  logic [15:0] p_q;
  logic        p_zero;
  logic        p_wrap;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_register_bank u_dut (
    .clk (clk), .rst_n (rst_n), .load (load), .load_addr (load_addr),
    .data_in (data_in), .cnt_op (cnt_op), .cnt_addr (cnt_addr),
    .bus_oe (bus_oe), .bus_addr (bus_addr), .q_bus (q_bus),
    .rd_addr (rd_addr), .q (q), .zero (zero), .wrap (wrap)
  );

  cpu_register_bank #(.WIDTH(16), .DEPTH(8)) u_dut16 (
    .clk (clk), .rst_n (rst_n), .load (p_load), .load_addr (p_load_addr),
    .data_in (p_data_in), .cnt_op (p_cnt_op), .cnt_addr (p_cnt_addr),
    .bus_oe (p_bus_oe), .bus_addr (p_bus_addr), .q_bus (p_q_bus),
    .rd_addr (p_rd_addr), .q (p_q), .zero (p_zero), .wrap (p_wrap)
  );

  typedef struct {
    logic       ld;
    logic [1:0] la;
    logic [7:0] din;
    logic [1:0] op;
    logic [1:0] ca;
    logic       oe;
    logic [1:0] ba;
    logic [1:0] ra;
    logic [7:0] eq;
    logic       ez;
    logic       ew;
    logic [7:0] eb;
  } vec_t;

  typedef struct {
    logic [7:0] eq;
    logic       ez;
    logic       ew;
    logic       oe;
    logic [7:0] eb;
  } exp_t;

  exp_t sb[$];
  vec_t tv[14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // A released bus reads as z in four-state simulation and as 0 in two-state.
  function automatic logic released(input logic [7:0] v);
    return (v === 8'hzz) || (v === 8'h00);
  endfunction

  initial begin
    logic [7:0] exp_load_q;
    exp_t e;

    tv[0]  = '{1'b1, 2'd2, 8'hA5, 2'd0, 2'd0, 1'b1, 2'd2, 2'd2, 8'hA5, 1'b0, 1'b0, 8'hA5};
    tv[1]  = '{1'b1, 2'd3, 8'hFF, 2'd0, 2'd0, 1'b0, 2'd2, 2'd3, 8'hFF, 1'b0, 1'b0, 8'h00};
    tv[2]  = '{1'b0, 2'd0, 8'h00, 2'd1, 2'd3, 1'b0, 2'd2, 2'd3, 8'h00, 1'b1, 1'b1, 8'h00};
    tv[3]  = '{1'b0, 2'd0, 8'h00, 2'd2, 2'd3, 1'b0, 2'd2, 2'd3, 8'hFF, 1'b0, 1'b1, 8'h00};
    tv[4]  = '{1'b1, 2'd1, 8'h10, 2'd0, 2'd0, 1'b0, 2'd0, 2'd1, 8'h10, 1'b0, 1'b0, 8'h00};
    tv[5]  = '{1'b0, 2'd0, 8'h00, 2'd1, 2'd1, 1'b0, 2'd0, 2'd1, 8'h11, 1'b0, 1'b0, 8'h00};
    tv[6]  = '{1'b1, 2'd1, 8'h33, 2'd1, 2'd1, 1'b0, 2'd0, 2'd1, 8'h33, 1'b0, 1'b0, 8'h00};
    tv[7]  = '{1'b1, 2'd0, 8'h44, 2'd1, 2'd1, 1'b1, 2'd0, 2'd1, 8'h34, 1'b0, 1'b0, 8'h44};
    tv[8]  = '{1'b0, 2'd0, 8'h00, 2'd3, 2'd1, 1'b1, 2'd3, 2'd1, 8'h00, 1'b1, 1'b0, 8'hFF};
    tv[9]  = '{1'b1, 2'd3, 8'hAB, 2'd1, 2'd3, 1'b0, 2'd0, 2'd3, 8'hAB, 1'b0, 1'b0, 8'h00};
    tv[10] = '{1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 1'b1, 2'd3, 2'd2, 8'hA5, 1'b0, 1'b0, 8'hAB};
    tv[11] = '{1'b0, 2'd0, 8'h00, 2'd2, 2'd0, 1'b0, 2'd0, 2'd0, 8'h43, 1'b0, 1'b0, 8'h00};
    tv[12] = '{1'b1, 2'd2, 8'h00, 2'd0, 2'd0, 1'b1, 2'd2, 2'd2, 8'h00, 1'b1, 1'b0, 8'h00};
    tv[13] = '{1'b0, 2'd0, 8'h00, 2'd2, 2'd2, 1'b0, 2'd0, 2'd2, 8'hFF, 1'b0, 1'b1, 8'h00};

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_q", 32'(q), 32'h0);
    check("rst_zero", 32'(zero), 32'h1);
    check("rst_wrap", 32'(wrap), 32'h0);
    check("rst_bus_release", 32'(released(q_bus)), 32'h1);
    bus_oe = 1'b1;
    #1 check("rst_bus_driven", 32'(q_bus), 32'h0);
    bus_oe = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // Table vectors: outputs checked after the edge with write ports idled
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      load = tv[i].ld; load_addr = tv[i].la; data_in = tv[i].din;
      cnt_op = tv[i].op; cnt_addr = tv[i].ca; bus_oe = tv[i].oe;
      bus_addr = tv[i].ba; rd_addr = tv[i].ra;
      sb.push_back('{tv[i].eq, tv[i].ez, tv[i].ew, tv[i].oe, tv[i].eb});
      @(posedge clk);
      #1 load = 1'b0; cnt_op = 2'd0;
      #1;
      e = sb.pop_front();
      check($sformatf("vec%0d_q", i), 32'(q), 32'(e.eq));
      check($sformatf("vec%0d_zero", i), 32'(zero), 32'(e.ez));
      check($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(e.ew));
      if (e.oe)
        check($sformatf("vec%0d_bus", i), 32'(q_bus), 32'(e.eb));
      else
        check($sformatf("vec%0d_bus_release", i), 32'(released(q_bus)), 32'h1);
    end

    // Wrap pulse lasts exactly one cycle
    @(posedge clk);
    #1 check("wrap_one_cycle", 32'(wrap), 32'h0);

    // Load latency and immediate bus release; reg2 holds 0xFF here
`ifdef CPU_REGISTER_BANK_BYPASS_EN
    exp_load_q = 8'h5A;
`else
    exp_load_q = 8'hFF;
`endif
    @(negedge clk);
    load = 1'b1; load_addr = 2'd2; data_in = 8'h5A;
    rd_addr = 2'd2; bus_addr = 2'd2; bus_oe = 1'b1;
    #1;
    check("lat_same_cycle_q", 32'(q), 32'(exp_load_q));
    check("lat_same_cycle_bus", 32'(q_bus), 32'(exp_load_q));
    @(posedge clk);
    #1 load = 1'b0;
    #1 check("lat_next_cycle_q", 32'(q), 32'h5A);
    bus_oe = 1'b0;
    #1 check("bus_release_now", 32'(released(q_bus)), 32'h1);

    // Mid-cycle reset: pending wrap and in-flight ops are lost
    @(negedge clk);
    load = 1'b1; load_addr = 2'd1; data_in = 8'h5A;
    @(negedge clk);
    load_addr = 2'd3; data_in = 8'hFF;
    @(negedge clk);
    load = 1'b0; cnt_op = 2'd1; cnt_addr = 2'd3; rd_addr = 2'd1;
    @(posedge clk);
    #1 check("pre_rst_wrap", 32'(wrap), 32'h1);
    check("pre_rst_q1", 32'(q), 32'h5A);
    load = 1'b1; load_addr = 2'd0; data_in = 8'h77; cnt_op = 2'd1; cnt_addr = 2'd2;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_wrap", 32'(wrap), 32'h0);
    check("midrst_q", 32'(q), 32'h0);
    check("midrst_zero", 32'(zero), 32'h1);
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1 check($sformatf("midrst_reg%0d", a), 32'(q), 32'h0);
    end
    bus_oe = 1'b1; bus_addr = 2'd1;
    #1 check("midrst_bus", 32'(q_bus), 32'h0);
    bus_oe = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; load = 1'b0; cnt_op = 2'd0;
    @(posedge clk);
    rd_addr = 2'd0;
    #1 check("post_rst_reg0", 32'(q), 32'h0);
    rd_addr = 2'd2;
    #1 check("post_rst_reg2", 32'(q), 32'h0);

    // Wide configuration: INC at all-ones on the last register
    @(negedge clk);
    p_load = 1'b1; p_load_addr = 3'd7; p_data_in = 16'hFFFF;
    @(negedge clk);
    p_load_addr = 3'd3; p_data_in = 16'h1234;
    @(negedge clk);
    p_load_addr = 3'd0; p_data_in = 16'h00AA;
    @(negedge clk);
    p_load = 1'b0; p_cnt_op = 2'd1; p_cnt_addr = 3'd7; p_rd_addr = 3'd7;
    @(posedge clk);
    #1 p_cnt_op = 2'd0;
    #1;
    check("w16_q7", 32'(p_q), 32'h0);
    check("w16_zero", 32'(p_zero), 32'h1);
    check("w16_wrap", 32'(p_wrap), 32'h1);
    for (int a = 0; a < 7; a++) begin
      p_rd_addr = 3'(a);
      #1 check($sformatf("w16_reg%0d", a), 32'(p_q),
               (a == 3) ? 32'h1234 : ((a == 0) ? 32'h00AA : 32'h0));
    end
    p_bus_oe = 1'b1; p_bus_addr = 3'd3;
    #1 check("w16_bus", 32'(p_q_bus), 32'h1234);
    @(posedge clk);
    #1 check("w16_wrap_end", 32'(p_wrap), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_register_bank.md
Name: cpu_register_bank

Overview:
- Parametrised successor to the single 8-bit bus register.
- Holds DEPTH registers of WIDTH bits, with one write port and one counter-op port (PC/SP style increment, decrement, clear).
- Provides one tristated bus read port and one always-driven direct read port.
- Sits between the shared data bus and the control unit; serves as the general-purpose, pointer and counter registers.

Parameters:
- WIDTH, 8, bits per register (≥2).
- DEPTH, 4, number of registers (power of two, ≥2).
- ADDR_W, $clog2(DEPTH), address width; derived, never overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- load  in  1  write enable.
- load_addr  in  ADDR_W  write target.
- data_in  in  WIDTH  write data.
- cnt_op  in  2  counter op (cnt_op_t: NOP=0, INC=1, DEC=2, CLR=3).
- cnt_addr  in  ADDR_W  counter-op target.
- bus_oe  in  1  drive q_bus when high.
- bus_addr  in  ADDR_W  register driven onto q_bus.
- q_bus  out  WIDTH  tristate bus output; 'z' when bus_oe=0.
- rd_addr  in  ADDR_W  direct read select.
- q  out  WIDTH  direct read data, always driven.
- zero  out  1  high when q == 0 (combinational on q).
- wrap  out  1  registered one-cycle pulse on counter wrap-around.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low: rst_n=0 immediately clears all registers and wrap to 0. Release takes effect at the next rising clk.
- Outputs under reset: q_bus is 'z' when bus_oe=0, otherwise all zeros. q=0, zero=1.
- Write: load=1 stores data_in into reg[load_addr] at the rising edge. Visible on q/q_bus the following cycle (1-cycle latency).
- Counter ops on reg[cnt_addr], applied at the rising edge:
  - INC: +1 modulo 2^WIDTH.
  - DEC: −1 modulo 2^WIDTH.
  - CLR: set to 0.
  - NOP: hold.
- Wrap:
  - wrap=1 for exactly the cycle after an INC from all-ones to 0, or a DEC from 0 to all-ones, provided the op was not overridden.
  - wrap=0 otherwise, including CLR and NOP.
- Collision: load=1 with load_addr==cnt_addr means load wins. The counter op is discarded and wrap stays 0.
- Different addresses: load and counter op both take effect in the same cycle.
- Unaddressed registers hold their value.
- Reads: q and q_bus are combinational muxes of current register contents. Reading the address being written returns the old value, unless BYPASS_EN is defined.
- Bus release: bus_oe deasserts to 'z' combinationally, with no cycle delay.
- Reset mid-operation: an in-flight load or counter op is lost, and any pending wrap pulse is cancelled.

Optional Feature:
- Macro: CPU_REGISTER_BANK_BYPASS_EN.
- Defined: when load=1 and load_addr equals rd_addr (or bus_addr), q (or q_bus) shows data_in combinationally in the same cycle. Counter-op results are not forwarded.
- Undefined: no forwarding; the written value appears the cycle after the write.
- Register-state behaviour is identical in both builds.

Decomposition:
- cpu_register_pkg holds:
  - typedef enum logic [1:0] cnt_op_t (NOP, INC, DEC, CLR);
  - localparam defaults for WIDTH and DEPTH.
- Sub-module cpu_register_cell: one WIDTH register with async active-low reset, load/op priority and wrap detect. Instantiated DEPTH times via generate.
- Top level: address decode, the load-over-op collision rule, read muxes, tristate, wrap OR-reduction and output flop.

Test Plan:
1. Reset then read: rst_n=0 mid-cycle with reg[1]=0x5A → q and all registers read 0x00 immediately. zero=1; q_bus='z' when bus_oe=0.
2. Load/read latency: load reg[2]=0xA5 → q=0x00 in the load cycle (without bypass), 0xA5 the next cycle. bus_oe=1, bus_addr=2 → q_bus=0xA5; bus_oe=0 → 'z'.
3. Wrap: reg[3]=0xFF, INC → reg[3]=0x00 and wrap=1 for one cycle. Then DEC → 0xFF and wrap=1. INC from 0x10 → 0x11, wrap=0.
4. Collision: load reg[1]=0x33 with INC on addr 1 → reg[1]=0x33, wrap=0. Load reg[0]=0x44 with INC on reg[1]=0x33 → 0x44 and 0x34 in the same cycle.
5. Bypass build: load reg[0]=0x7E, rd_addr=0 → q=0x7E in the same cycle. In the non-bypass build, q shows the old value.
6. Parameter sweep: WIDTH=16, DEPTH=8, INC at 0xFFFF on reg[7] → 0x0000 with wrap=1; other registers unchanged.
